mt6835_spi_emulator: RTL
========================

// Module: mt6835_spi_emulator
// PURPOSE
//  SPI mode-3 (CPOL=1, CPHA=1) slave that emulates the MT6835 angle sensor.
//  It responds to the angle-read command with a 16-bit angle, MSB first.
//  Used in simulation and HIL builds in place of the real encoder, so the FOC
//  loop and the SPI angle reader can run without hardware.
//  The angle comes from a motor model or a test register.
// PARAMETERS
//  CMD_READ     8'h83  command byte that selects the angle response
//  DATA_W       16     angle width; frame = 8 + DATA_W bits
//  SYNC_STAGES  2      flip-flop synchronizer depth on csn/sck/mosi (>=2)
// PORTS
//  clk          in   1       system clock; only clock in the block
//  rst          in   1       asynchronous, active-high reset
//  angle_in     in   DATA_W  live angle from the model; snapshotted at frame start
//  csn          in   1       SPI chip select, active low, async to clk
//  sck          in   1       SPI clock, idles high, async to clk
//  mosi         in   1       SPI data from the master, async to clk
//  miso         out  1       SPI data to the master
//  miso_oe      out  1       MISO output enable; 1 only while csn is low (sync)
//  cmd_byte     out  8       last command byte received
//  cmd_valid    out  1       1-clk pulse when the 8th command bit is sampled
//  frame_done   out  1       1-clk pulse at csn rise after >= 8+DATA_W sck rises
//  frame_err    out  1       1-clk pulse at csn rise after < 8+DATA_W sck rises
// BEHAVIOUR
//  - Reset values: miso=0, miso_oe=0, cmd_byte=0, all pulses 0, FSM in IDLE.
//    Synchronizers reset to idle levels: csn=1, sck=1, mosi=0.
//  - Edge detection: runs on the synchronized signals, comparing current and
//    previous sample. An edge becomes visible SYNC_STAGES+1 clk after the pin.
//  - Frame start (detected csn fall): snapshot angle_in into tx_reg and clear
//    bit_cnt. State goes to CMD; miso=0; miso_oe=1.
//  - CMD: on each sck rise, rx = {rx[6:0], mosi} and bit_cnt++.
//    * At bit_cnt==8: cmd_byte<=rx, pulse cmd_valid, go to DATA.
//    * If rx==CMD_READ, load shift reg = tx_reg; otherwise load all zeros.
//    * Drive miso = shift[MSB] in the same cycle.
//  - DATA: on each sck rise, shift left and drive the new MSB.
//    * MISO changes SYNC_STAGES+1 clk after the sck rise, which leaves the
//      whole low half-period as setup margin for the master.
//    * Mode-3 falling-edge timing is met because MISO is stable well before
//      the next rise.
//    * After DATA_W shifts, go to TAIL.
//  - TAIL: extra sck edges drive miso=0; the counter saturates (no wrap).
//  - Frame end (detected csn rise) in any non-IDLE state:
//    * Go to IDLE; miso_oe=0; miso=0.
//    * Pulse frame_done if bit_cnt >= 8+DATA_W, otherwise pulse frame_err.
//  - If csn rise and sck rise are detected in the same clk, csn wins: the
//    bit is discarded.
//  - sck edges while csn is high are ignored. A csn fall detected in any
//    state restarts the frame.
//  - angle_in changes mid-frame do not affect the frame in progress.
//  - Async rst mid-frame: returns to the reset values at once. A frame with
//    csn already low is ignored until csn is seen high, then low again.
//  - Timing constraint: each sck half-period >= SYNC_STAGES+3 clk periods.
// STRUCTURE
//  - Shared package: FSM state enum (IDLE, CMD, DATA, TAIL), CMD_READ
//    default, frame-length constant 8+DATA_W.
//  - One sub-module, spi_pin_sync: SYNC_STAGES synchronizer plus rise/fall
//    detector, instanced three times (csn, sck, mosi).
//  - Top level: FSM, 5-bit saturating bit_cnt, rx/tx shift registers.
// TESTING
//  1. angle_in=16'hA5C3, master sends 8'h83 then 16 clocks:
//     master reads 16'hA5C3, cmd_byte=83, one cmd_valid, one frame_done.
//  2. Command 8'h05: all 16 data bits read 0; cmd_byte=05; frame_done pulses.
//  3. angle_in changes 1234->FFFF 3 clocks after csn falls:
//     the read returns 16'h1234.
//  4. csn raised after 12 sck rises: frame_err pulses, no frame_done,
//     miso_oe=0 within SYNC_STAGES+2 clk; next full frame reads correctly.
//  5. 25 sck rises in one frame: first 24 bits correct, bit 25 reads 0,
//     frame_done pulses.
//  6. rst asserted at data bit 6: outputs go to reset values at once; after
//     release, a fresh frame reads angle_in correctly.

Source files
------------

// File: rtl/mt6835_spi_emulator_pkg.sv
`default_nettype none
// ============================================================================
// mt6835_spi_emulator_pkg : shared FSM states and frame constants
// Revision: 1.0
// ============================================================================
package mt6835_spi_emulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } state_e;

  localparam logic [7:0]  CMD_READ_DEFAULT = 8'h83;
  localparam int unsigned DATA_W_DEFAULT   = 16;
  localparam int unsigned CMD_W            = 8;

  function automatic int unsigned frame_len(input int unsigned data_w);
    return CMD_W + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mt6835_spi_emulator_pin_sync.sv
`default_nettype none
// ============================================================================
// spi_pin_sync : multi-flop synchronizer with rise/fall detection
// Revision: 1.0
// ============================================================================
module spi_pin_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   vld_q;

  // Edges are held off until the chain has been refilled from the pin since
  // reset, so a level already present at reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = vld_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = vld_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/mt6835_spi_emulator.sv
`default_nettype none
// ============================================================================
// mt6835_spi_emulator : SPI mode-3 slave emulating the MT6835 angle read
// Revision: 1.0
// ============================================================================
module mt6835_spi_emulator
  import mt6835_spi_emulator_pkg::*;
#(
  parameter logic [7:0]  CMD_READ    = CMD_READ_DEFAULT,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] angle_in,
  input  logic              csn,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [7:0]        cmd_byte,
  output logic              cmd_valid,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned FRAME_LEN = frame_len(DATA_W);
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);

  logic csn_lvl, csn_rise, csn_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst(rst), .pin_i(csn),
    .level_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
    .clk(clk), .rst(rst), .pin_i(sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin_i(mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_sync = ^{csn_lvl, sck_lvl, sck_fall, mosi_rise, mosi_fall};

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [7:0]        rx_q,       rx_d;
  logic [DATA_W-1:0] tx_q,       tx_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic              miso_q,     miso_d;
  logic              oe_q,       oe_d;
  logic [7:0]        cmd_byte_q, cmd_byte_d;
  logic              cmd_vld_q,  cmd_vld_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [7:0]        rx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      shift_q    <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      cmd_byte_q <= '0;
      cmd_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      cmd_byte_q <= cmd_byte_d;
      cmd_vld_q  <= cmd_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    cmd_byte_d = cmd_byte_q;
    cmd_vld_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_inc    = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;
    rx_shift   = {rx_q[6:0], mosi_lvl};

    // csn edges take priority, so an sck rise coincident with csn rise is dropped.
    if (csn_fall) begin
      state_d   = ST_CMD;
      tx_d      = angle_in;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b1;
    end else if (csn_rise) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
        done_d  = (bit_cnt_q >= CNT_FRAME);
        err_d   = (bit_cnt_q <  CNT_FRAME);
      end
    end else if (sck_rise && (state_q != ST_IDLE)) begin
      bit_cnt_d = cnt_inc;
      unique case (state_q)
        ST_CMD: begin
          rx_d = rx_shift;
          if (cnt_inc == CNT_CMD) begin
            cmd_byte_d = rx_shift;
            cmd_vld_d  = 1'b1;
            state_d    = ST_DATA;
            shift_d    = (rx_shift == CMD_READ) ? tx_q : '0;
            miso_d     = shift_d[DATA_W-1];
          end
        end
        ST_DATA: begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          miso_d  = shift_q[DATA_W-2];
          if (cnt_inc == CNT_FRAME) state_d = ST_TAIL;
        end
        ST_TAIL: miso_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = oe_q;
  assign cmd_byte   = cmd_byte_q;
  assign cmd_valid  = cmd_vld_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
`default_nettype wire
